ir_sweep_sched: RTL
===================

# ir_sweep_sched

Scheduler that shares the single A2D converter interface among the six line-sensing IR channels of the follower. It sequences three emitter pairs (inner, middle, outer) through enable, settle, convert-right and convert-left steps, and accumulates a weighted signed error. It publishes that error once per sweep to the motion PI math. Sweeps run only while the command processor asserts `go`.

## Interface
Parameters:
- SETTLE_CYC, 4096: cycles an emitter is on before its first conversion; must be ≥2.
- SETTLE_W, 13: width of the settle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; synchronous, active-high
- go  in  1  sweep enable from the command processor
- strt_cnv  out  1  one-cycle start pulse to the A2D interface
- chnnl  out  3  A2D channel select; stable from `strt_cnv` until `cnv_cmplt`
- cnv_cmplt  in  1  one-cycle conversion-done pulse from the A2D interface
- res  in  12  unsigned conversion result; valid only with `cnv_cmplt`
- IR_in_en, IR_mid_en, IR_out_en  out  1 each  emitter enables
- error  out  16  signed weighted error; holds its value between updates
- err_vld  out  1  one-cycle pulse when `error` updates
- busy  out  1  high in every state except IDLE

## Operation
- Pair order and channels (right, left): inner (1, 0), mid (4, 2), outer (3, 7). Weight shifts are 0, 1, 2 (×1, ×2, ×4).
- States: IDLE, SETTLE, CONV_R, WAIT_R, CONV_L, WAIT_L, DONE.
- IDLE, `go`=1 → SETTLE, pair=inner, accumulator cleared.
- SETTLE: the current pair's emitter is on and the counter runs. When the count reaches SETTLE_CYC−1 → CONV_R.
- CONV_R: `strt_cnv`=1 for exactly one cycle, `chnnl`=right channel → WAIT_R.
- WAIT_R: on `cnv_cmplt`, acc += zero-extend(`res`)<<shift → CONV_L.
- CONV_L and WAIT_L mirror CONV_R and WAIT_R on the left channel, with acc −= `res`<<shift.
- WAIT_L completion: for inner and mid pairs, go to SETTLE with the next pair; for the outer pair, go to DONE.
- DONE: `error` ← acc, `err_vld`=1. Then go to SETTLE (inner pair, acc cleared) if `go`, else IDLE.
- Emitter of the current pair is on from SETTLE through WAIT_L. At most one emitter is on at any time.
- Arithmetic is 16-bit signed. The bound is ±4095×7=±28665, so no overflow or saturation logic is needed.
- `cnv_cmplt` outside WAIT_R and WAIT_L is ignored.
- Abort when `go` falls mid-sweep:
  - In SETTLE: go to IDLE next cycle.
  - In CONV_x or WAIT_x: finish the in-flight conversion, discard its result, then go to IDLE. The A2D interface is never left busy.
  - After an abort there is no `err_vld`, and `error` keeps its last value.
- Reset: state IDLE; `strt_cnv`, `chnnl`, all emitter enables, `err_vld`, `busy` = 0; `error` = 0; accumulator and counter = 0. Reset overrides any state, including mid-conversion.

## Timing
- Outputs are registered or decoded from state. Changes are visible the cycle after the causing edge.
- `go` sampled high in IDLE → emitter on and `busy`=1 next cycle.
- Emitter on → `strt_cnv` exactly SETTLE_CYC cycles later.
- `cnv_cmplt` → next `strt_cnv` (same pair, left channel) 1 cycle later. Pair change adds SETTLE_CYC cycles.
- Sweep latency: 3×(SETTLE_CYC+2) cycles plus six A2D latencies, plus 1 DONE cycle.
- With `go` held, the next sweep's SETTLE begins the cycle after DONE.
- `go` rising during DONE has no extra effect.

## Structure
- Shared package `ir_pkg`:
  - state enum
  - channel constants `CH_IN_R=1, CH_IN_L=0, CH_MID_R=4, CH_MID_L=2, CH_OUT_R=3, CH_OUT_L=7`
  - weight shift constants
  - SETTLE_CYC default
- One sub-module, `settle_timer`: SETTLE_W-bit counter with synchronous clear and an `expired` flag at SETTLE_CYC−1.
- FSM, pair index, accumulator and output register stay in the top module.

## Test plan
Bench uses SETTLE_CYC=8 and an A2D model answering 10 cycles after `strt_cnv`.
- Reset: hold `rst` 2 cycles mid-stream → all outputs 0, `error`=0, `busy`=0 the cycle after.
- Balanced sweep: `go`=1, all results 100 → `chnnl` order 1,0,4,2,3,7; six `strt_cnv` pulses; one `err_vld` with `error`=0. Only one emitter is on at any time.
- Weighting: right=200, left=100 → `error`=700. Left=4095, right=0 → `error`=−28665 (0x9007).
- Abort: drop `go` during WAIT_L of the mid pair → `IR_mid_en` stays on until `cnv_cmplt`, then all emitters off and IDLE the next cycle. No `err_vld`; `error` holds 700.
- Continuous run with `go` held: SETTLE restarts the cycle after DONE, and `err_vld` pulses are spaced exactly one sweep period apart. A stray `cnv_cmplt` injected in SETTLE has no effect on `error`.
- Reset mid-WAIT_R → IDLE next cycle, all outputs 0. A late `cnv_cmplt` afterwards is ignored.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: shared types and constants for the IR sweep scheduler.
//   state_t : scheduler FSM states
//   pair_t  : emitter pair index (inner, mid, outer)
//   CH_*    : A2D channel numbers for the right/left sensor of each pair
//   SHIFT_* : error weight shifts per pair (x1, x2, x4)
//   helpers : channel lookup and weighted (shifted, zero-extended) result
package ir_pkg;

  localparam int SETTLE_CYC_DEF = 4096;
  localparam int SETTLE_W_DEF   = 13;
  localparam int RES_W          = 12;
  localparam int ERR_W          = 16;
  localparam int CH_W           = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CONV_R = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_CONV_L = 3'd4,
    ST_WAIT_L = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PAIR_IN  = 2'd0,
    PAIR_MID = 2'd1,
    PAIR_OUT = 2'd2
  } pair_t;

  localparam logic [CH_W-1:0] CH_IN_R  = 3'd1;
  localparam logic [CH_W-1:0] CH_IN_L  = 3'd0;
  localparam logic [CH_W-1:0] CH_MID_R = 3'd4;
  localparam logic [CH_W-1:0] CH_MID_L = 3'd2;
  localparam logic [CH_W-1:0] CH_OUT_R = 3'd3;
  localparam logic [CH_W-1:0] CH_OUT_L = 3'd7;

  localparam int SHIFT_IN  = 0;
  localparam int SHIFT_MID = 1;
  localparam int SHIFT_OUT = 2;

  function automatic logic [CH_W-1:0] right_ch(input pair_t p);
    case (p)
      PAIR_IN:  return CH_IN_R;
      PAIR_MID: return CH_MID_R;
      default:  return CH_OUT_R;
    endcase
  endfunction

  function automatic logic [CH_W-1:0] left_ch(input pair_t p);
    case (p)
      PAIR_IN:  return CH_IN_L;
      PAIR_MID: return CH_MID_L;
      default:  return CH_OUT_L;
    endcase
  endfunction

  // Zero-extend before shifting so the x4 weight of a full-scale result
  // (16380) still fits as a positive 16-bit signed value.
  function automatic logic [ERR_W-1:0] weighted(input pair_t p, input logic [RES_W-1:0] r);
    logic [ERR_W-1:0] z;
    z = {{(ERR_W-RES_W){1'b0}}, r};
    case (p)
      PAIR_IN:  return z << SHIFT_IN;
      PAIR_MID: return z << SHIFT_MID;
      default:  return z << SHIFT_OUT;
    endcase
  endfunction

endpackage

// File: rtl/ir_sweep_sched_if.sv
// ir_sweep_sched_if: handshake between the sweep scheduler and the A2D
// converter interface.
//   strt_cnv  : one-cycle conversion start (scheduler -> A2D)
//   chnnl     : channel select, held from strt_cnv until cnv_cmplt
//   cnv_cmplt : one-cycle conversion done (A2D -> scheduler)
//   res       : unsigned result, valid only with cnv_cmplt
interface ir_sweep_sched_if;
  import ir_pkg::*;

  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);

endinterface

// File: rtl/ir_sweep_sched_settle_timer.sv
// settle_timer: emitter settle counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear; count restarts from 0 the next cycle
//   expired  : high while the count equals SETTLE_CYC-1
// The count holds at SETTLE_CYC-1 so a stalled consumer never sees it wrap.
module settle_timer
  import ir_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SETTLE_W   = SETTLE_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE_CYC - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ir_sweep_sched.sv
// ir_sweep_sched: shares the A2D interface among the six IR line sensors.
// Each sweep walks the inner, mid and outer emitter pairs through settle,
// right conversion and left conversion, accumulating
// sum((right - left) << weight), and publishes the result once per sweep.
//   clk, rst   : clock, synchronous active-high reset
//   go         : sweep enable; dropping it aborts cleanly
//   a2d        : A2D handshake (strt_cnv, chnnl, cnv_cmplt, res)
//   IR_*_en    : emitter enables, at most one high
//   error      : signed weighted error, holds between updates
//   err_vld    : one-cycle pulse when error updates
//   busy       : high outside IDLE
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for go, emitters off
// SETTLE    | current pair's emitter on, settle timer running
// CONV_R    | strt_cnv pulse on the pair's right channel
// WAIT_R    | waiting for right result, add weighted result
// CONV_L    | strt_cnv pulse on the pair's left channel
// WAIT_L    | waiting for left result, subtract, advance pair
// DONE      | error published, err_vld high
module ir_sweep_sched
  import ir_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SETTLE_W   = SETTLE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  ir_sweep_sched_if.master        a2d,
  output logic                    IR_in_en,
  output logic                    IR_mid_en,
  output logic                    IR_out_en,
  output logic signed [ERR_W-1:0] error,
  output logic                    err_vld,
  output logic                    busy
);

  state_t                  state_q, state_d;
  pair_t                   pair_q, pair_d;
  logic signed [ERR_W-1:0] acc_q, acc_d;
  logic signed [ERR_W-1:0] error_q, error_d;
  logic                    abort_q, abort_d;
  logic                    abort_now;
  logic                    tmr_clr;
  logic                    tmr_expired;
  logic [ERR_W-1:0]        term;
  logic                    emit_on;

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC),
    .SETTLE_W   (SETTLE_W)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .expired (tmr_expired)
  );

  // Counter only runs in SETTLE, so it is always 0 on entry.
  assign tmr_clr = (state_q != ST_SETTLE);

  assign term = weighted(pair_q, a2d.res);

  // Once go drops during a conversion the sweep is doomed, even if go
  // comes back before the A2D answers.
  assign abort_now = abort_q | ~go;

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    acc_d   = acc_q;
    error_d = error_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (go) begin
          state_d = ST_SETTLE;
          pair_d  = PAIR_IN;
          acc_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!go) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          state_d = ST_CONV_R;
        end
      end
      ST_CONV_R: begin
        abort_d = abort_now;
        state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        abort_d = abort_now;
        if (a2d.cnv_cmplt) begin
          if (abort_now) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
          end else begin
            acc_d   = acc_q + $signed(term);
            state_d = ST_CONV_L;
          end
        end
      end
      ST_CONV_L: begin
        abort_d = abort_now;
        state_d = ST_WAIT_L;
      end
      ST_WAIT_L: begin
        abort_d = abort_now;
        if (a2d.cnv_cmplt) begin
          if (abort_now) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
          end else begin
            acc_d = acc_q - $signed(term);
            if (pair_q == PAIR_OUT) begin
              error_d = acc_q - $signed(term);
              state_d = ST_DONE;
            end else begin
              pair_d  = (pair_q == PAIR_IN) ? PAIR_MID : PAIR_OUT;
              state_d = ST_SETTLE;
            end
          end
        end
      end
      ST_DONE: begin
        if (go) begin
          state_d = ST_SETTLE;
          pair_d  = PAIR_IN;
          acc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pair_q  <= PAIR_IN;
      acc_q   <= '0;
      error_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      acc_q   <= acc_d;
      error_q <= error_d;
      abort_q <= abort_d;
    end
  end

  // Outputs decode directly from the state register.
  assign a2d.strt_cnv = (state_q == ST_CONV_R) || (state_q == ST_CONV_L);

  always_comb begin
    a2d.chnnl = '0;
    case (state_q)
      ST_CONV_R, ST_WAIT_R: a2d.chnnl = right_ch(pair_q);
      ST_CONV_L, ST_WAIT_L: a2d.chnnl = left_ch(pair_q);
      default:              a2d.chnnl = '0;
    endcase
  end

  assign emit_on   = (state_q == ST_SETTLE) || (state_q == ST_CONV_R) ||
                     (state_q == ST_WAIT_R) || (state_q == ST_CONV_L) ||
                     (state_q == ST_WAIT_L);
  assign IR_in_en  = emit_on && (pair_q == PAIR_IN);
  assign IR_mid_en = emit_on && (pair_q == PAIR_MID);
  assign IR_out_en = emit_on && (pair_q == PAIR_OUT);

  assign error   = error_q;
  assign err_vld = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);

endmodule
